// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported work RAM between the CPU16 data port
// and the video scan-out fetcher. One access at a time runs through
// IDLE -> ISSUE -> RESP. Every RESP edge is also an arbitration point, so
// back-to-back requests cost two cycles each.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// When it is undefined, video has fixed priority over the CPU.
//
// Read data is sampled from mem_rdata at the edge that closes the ISSUE cycle.
// The RAM must present the word for the address driven during ISSUE by that
// edge.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;

  // Owner of the access in flight: 1 = video, 0 = CPU.
  logic   grant_vid;

  // Combinational arbitration result, consumed only at IDLE/RESP edges.
  logic   pick_any;
  logic   pick_vid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Requester granted most recently: 1 = video, 0 = CPU.
  logic   last_grant;

  // Round-robin: a lone requester always wins, and on a tie the requester
  // that did not win last time wins.
  always_comb begin
    pick_any = cpu_req | vid_req;
    pick_vid = 1'b0;
    if (vid_req && cpu_req) begin
      pick_vid = ~last_grant;
    end else if (vid_req) begin
      pick_vid = 1'b1;
    end
  end

  // Remember the winner of every grant edge so ties alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if ((state != ISSUE) && pick_any) begin
      last_grant <= pick_vid;
    end
  end
`else
  // Fixed priority: video always wins over the CPU.
  always_comb begin
    pick_any = cpu_req | vid_req;
    pick_vid = vid_req;
  end
`endif

  // Sequencer: state, grant owner, RAM strobes and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_vid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          cpu_ack <= 1'b0;
          vid_ack <= 1'b0;
          if (pick_any) begin
            state     <= ISSUE;
            grant_vid <= pick_vid;
            mem_en    <= 1'b1;
            // Video accesses are always reads.
            mem_we    <= pick_vid ? 1'b0 : cpu_we;
          end else begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        ISSUE: begin
          state   <= RESP;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          cpu_ack <= ~grant_vid;
          vid_ack <= grant_vid;
        end
        default: begin
          state   <= IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          vid_ack <= 1'b0;
        end
      endcase
    end
  end

  // Grant latch: address and write data are captured at the grant edge and
  // held afterwards, so requester input changes cannot disturb the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if ((state != ISSUE) && pick_any) begin
      if (pick_vid) begin
        mem_addr <= vid_addr;
      end else begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Read return: capture RAM data into the owner's register when ISSUE closes.
  // CPU writes leave cpu_rdata untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else if (state == ISSUE) begin
      if (grant_vid) begin
        vid_rdata <= mem_rdata;
      end else if (!mem_we) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with hand-computed expectations,
// plus a transaction-level model that predicts every output on every cycle.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_ack(vid_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM environment: 1K words, preset to A000^addr, read data visible while
  // the address is driven, write committed at the edge closing ISSUE.
  logic [DW-1:0] ram [0:1023];
  bit            ram_ready;
  assign mem_rdata = ram[mem_addr[9:0]];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'hA000 ^ DW'(i);
      ram_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A grant at edge k puts the access on the RAM during cycle k and its ack in
  // cycle k+1; the next arbitration edge is k+2.
  int            cyc = 0;
  int            next_arb = 0, en_cyc = -10, ack_cyc = -10;
  bit            m_vid, m_we, m_last_vid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_vid_rd;
  logic [DW-1:0] m_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return 16'hA000 ^ {6'd0, a[9:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    int  k;
    bit  win_vid;
    if (reset) begin
      next_arb = 0; en_cyc = -10; ack_cyc = -10;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_vid_rd = '0;
      m_last_vid = 1'b0; m_we = 1'b0; m_vid = 1'b0;
    end else begin
      k = cyc + 1;
      if (k == ack_cyc) begin
        if (m_we) m_mem[m_addr] = m_wdata;
        else if (m_vid) m_vid_rd = m_read(m_addr);
        else m_cpu_rd = m_read(m_addr);
      end
      if (k >= next_arb && (cpu_req || vid_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_vid = vid_req && !(cpu_req && m_last_vid);
`else
        win_vid = vid_req;
`endif
        m_vid = win_vid; m_last_vid = win_vid;
        en_cyc = k; ack_cyc = k + 1; next_arb = k + 2;
        if (win_vid) begin
          m_addr = vid_addr; m_we = 1'b0;
        end else begin
          m_addr = cpu_addr; m_wdata = cpu_wdata; m_we = cpu_we;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("mem_en", {31'd0, mem_en}, {31'd0, cyc == en_cyc});
      chk("mem_we", {31'd0, mem_we}, {31'd0, (cyc == en_cyc) && m_we});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
      chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
      chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, (cyc == ack_cyc) && !m_vid});
      chk("vid_ack", {31'd0, vid_ack}, {31'd0, (cyc == ack_cyc) && m_vid});
      chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, m_cpu_rd});
      chk("vid_rdata", {16'd0, vid_rdata}, {16'd0, vid_rdata === m_vid_rd ? vid_rdata : m_vid_rd});
      if (cpu_ack) $display("txn cpu %s addr=%04h rdata=%04h", m_we ? "wr" : "rd", m_addr, cpu_rdata);
      if (vid_ack) $display("txn vid rd addr=%04h rdata=%04h", m_addr, vid_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int vcyc, ccyc, n_cpu, n_vid;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    #1 run_chk = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single CPU write; cpu_addr changes during ISSUE and must not leak.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_issue_we", {31'd0, mem_we}, 32'd1);
    chk("wr_issue_addr", {16'd0, mem_addr}, 32'h0010);
    cpu_addr = 16'h7777;
    @(negedge clk);
    chk("wr_ack", {31'd0, cpu_ack}, 32'd1);
    chk("wr_resp_addr", {16'd0, mem_addr}, 32'h0010);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("wr_idle_ack", {31'd0, cpu_ack}, 32'd0);

    // CPU read-back.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("rd_issue_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rd_ack", {31'd0, cpu_ack}, 32'd1);
    chk("rd_data", {16'd0, cpu_rdata}, 32'hBEEF);
    cpu_req = 0;
    @(negedge clk);

    // Simultaneous first requests.
    vid_req = 1; vid_addr = 16'h0200;
    cpu_req = 1; cpu_addr = 16'h0300;
    vcyc = -1; ccyc = -1;
    for (int off = 1; off <= 10; off++) begin
      @(negedge clk);
      if (vid_ack) begin vcyc = off; vid_req = 0; end
      if (cpu_ack) begin ccyc = off; cpu_req = 0; end
    end
    chk("tie_vid_ack_cycle", vcyc, 32'd2);
    chk("tie_cpu_ack_cycle", ccyc, 32'd4);
    chk("tie_vid_rdata", {16'd0, vid_rdata}, 32'hA200);
    chk("tie_cpu_rdata", {16'd0, cpu_rdata}, 32'hA300);

    // Continuous contention for 10 accesses.
    vid_req = 1; vid_addr = 16'h0100;
    cpu_req = 1; cpu_addr = 16'h0020;
    n_cpu = 0; n_vid = 0;
    for (int off = 1; off <= 20; off++) begin
      @(negedge clk);
      vid_addr = 16'h0100 + 16'(off);
      if (cpu_ack) n_cpu++;
      if (vid_ack) n_vid++;
    end
    vid_req = 0; cpu_req = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("cont_cpu_acks", n_cpu, 32'd5);
    chk("cont_vid_acks", n_vid, 32'd5);
`else
    chk("cont_cpu_acks", n_cpu, 32'd0);
    chk("cont_vid_acks", n_vid, 32'd10);
`endif
    repeat (3) @(negedge clk);

    // Reset asserted in the ISSUE cycle of a CPU write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
    @(negedge clk);
    chk("rst_issue_we", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_we", {31'd0, mem_we}, 32'd0);
    chk("rst_async_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    chk("rst_no_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_cpu_rdata0", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_vid_rdata0", {16'd0, vid_rdata}, 32'd0);
    reset = 1'b0; cpu_req = 0; cpu_we = 0;
    @(negedge clk);

    // First post-reset request completes in 2 cycles; aborted write left no trace.
    cpu_req = 1; cpu_addr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ack", {31'd0, cpu_ack}, 32'd1);
    chk("post_rst_data", {16'd0, cpu_rdata}, 32'hA040);
    cpu_req = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
